text_console_ctrl: RTL and testbench

- Character-stream console controller that owns the write port of the text display buffer (80x30 cells, 7-bit char codes, linear address = row*80 + col).
- Accepts one byte at a time from the CPU/IO side over a valid/ready handshake.
- Tracks a cursor and interprets control codes (LF, CR, BS, FF).
- Issues single-cycle buffer writes, and sequences full-screen clears, including an automatic clear after reset.

---
 rtl/text_console_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
// Console controller owning the text buffer write port: cursor tracking, control codes, full-screen clear.
// Optional build macro TEXT_CONSOLE_LINE_CLEAR_EN blanks each newly entered row (LINECLR state).
module text_console_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_in,
  output logic        char_ready,
  input  logic        clear_req,
  output logic        buffer_write_enable,
  output logic [11:0] position,
  output logic [6:0]  char_code,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [11:0] COLS_W = 12'(COLS);
  localparam logic [11:0] LAST   = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  XMAX   = 7'(COLS - 1);
  localparam logic [4:0]  YMAX   = 5'(ROWS - 1);
  localparam logic [6:0]  SPACE  = 7'h20;

`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, LINECLR} state_t;
  logic line_pend_q, line_pend_d;
`else
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`endif

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        we_d, busy_d;
  logic [11:0] pos_d;
  logic [6:0]  code_d, x_d;
  logic [4:0]  y_d, y_next;
  logic [11:0] row_base, cur_addr;

  assign row_base   = 12'(cursor_y) * COLS_W;
  assign cur_addr   = row_base + 12'(cursor_x);
  assign y_next     = (cursor_y == YMAX) ? '0 : cursor_y + 5'd1;
  assign char_ready = (state_q == IDLE) && !clear_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    pos_d   = position;
    code_d  = char_code;
    x_d     = cursor_x;
    y_d     = cursor_y;
    busy_d  = busy;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    line_pend_d = line_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (char_valid) begin
          state_d = WRITE;
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            we_d   = 1'b1;
            pos_d  = cur_addr;
            code_d = char_in[6:0];
            if (cursor_x == XMAX) begin
              x_d = '0;
              y_d = y_next;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
              line_pend_d = 1'b1;
`endif
            end else begin
              x_d = cursor_x + 7'd1;
            end
          end else begin
            case (char_in)
              8'h0A: begin
                x_d = '0;
                y_d = y_next;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
                line_pend_d = 1'b1;
`endif
              end
              8'h0D: x_d = '0;
              8'h08: begin
                if (cursor_x != '0) begin
                  x_d    = cursor_x - 7'd1;
                  we_d   = 1'b1;
                  pos_d  = cur_addr - 12'd1;
                  code_d = SPACE;
                end
              end
              8'h0C: begin
                state_d = CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
        if (line_pend_q) begin
          state_d     = LINECLR;
          cnt_d       = '0;
          busy_d      = 1'b1;
          line_pend_d = 1'b0;
        end
`endif
      end
      CLEAR: begin
        we_d   = 1'b1;
        pos_d  = cnt_q;
        code_d = SPACE;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
      // cursor_y already points at the new row when LINECLR starts
      LINECLR: begin
        we_d   = 1'b1;
        pos_d  = row_base + cnt_q;
        code_d = SPACE;
        if (cnt_q == COLS_W - 12'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          x_d     = '0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= CLEAR;
      cnt_q               <= '0;
      buffer_write_enable <= 1'b0;
      position            <= '0;
      char_code           <= '0;
      cursor_x            <= '0;
      cursor_y            <= '0;
      busy                <= 1'b1;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
      line_pend_q         <= 1'b0;
`endif
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      buffer_write_enable <= we_d;
      position            <= pos_d;
      char_code           <= code_d;
      cursor_x            <= x_d;
      cursor_y            <= y_d;
      busy                <= busy_d;
`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
      line_pend_q         <= line_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl at default 80x30 geometry.
module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        char_valid;
  logic [7:0]  char_in;
  logic        char_ready;
  logic        clear_req;
  logic        buffer_write_enable;
  logic [11:0] position;
  logic [6:0]  char_code;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int total = 0;
  int bad   = 0;

  text_console_ctrl #(.COLS(80), .ROWS(30)) dut (
    .clk                 (clk),
    .reset               (reset),
    .char_valid          (char_valid),
    .char_in             (char_in),
    .char_ready          (char_ready),
    .clear_req           (clear_req),
    .buffer_write_enable (buffer_write_enable),
    .position            (position),
    .char_code           (char_code),
    .cursor_x            (cursor_x),
    .cursor_y            (cursor_y),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (n == 5000) chk("ready_timeout", {31'd0, char_ready}, 32'd1);
  endtask

  // Leaves the bench one cycle after acceptance (the WRITE cycle).
  task automatic send(input logic [7:0] b);
    wait_ready();
    char_valid = 1'b1;
    char_in    = b;
    step();
    char_valid = 1'b0;
    char_in    = 8'h00;
  endtask

  task automatic run_clear(input string tag);
    int errs = 0;
    for (int i = 0; i < 2400; i++) begin
      step();
      if (buffer_write_enable !== 1'b1 || position !== 12'(i) || char_code !== 7'h20) errs++;
    end
    chk(tag, errs, 0);
    step();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, char_ready, 1);
    chk({tag, "_we_off"}, buffer_write_enable, 0);
    chk({tag, "_cx"}, cursor_x, 0);
    chk({tag, "_cy"}, cursor_y, 0);
  endtask

  initial begin
    int errs;
    reset      = 1'b0;
    char_valid = 1'b0;
    clear_req  = 1'b0;
    char_in    = 8'h00;
    #12;
    chk("rst_we", buffer_write_enable, 0);
    chk("rst_pos", position, 0);
    chk("rst_code", char_code, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", char_ready, 0);
    chk("rst_cx", cursor_x, 0);
    chk("rst_cy", cursor_y, 0);
    step();
    reset = 1'b1;
    run_clear("por_clear");

    send(8'h41);
    chk("A_we", buffer_write_enable, 1);
    chk("A_pos", position, 0);
    chk("A_code", char_code, 7'h41);
    chk("A_ready_low", char_ready, 0);
    step();
    send(8'h42);
    chk("B_we", buffer_write_enable, 1);
    chk("B_pos", position, 1);
    chk("B_code", char_code, 7'h42);
    chk("B_ready_low", char_ready, 0);
    step();
    chk("B_we_off", buffer_write_enable, 0);
    chk("B_cx", cursor_x, 2);
    chk("B_cy", cursor_y, 0);

    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 79; i++) send(8'h78);
    step();
    wait_ready();
    chk("pre_wrap_cx", cursor_x, 79);
    chk("pre_wrap_cy", cursor_y, 2);
    send(8'h5A);
    chk("wrap_we", buffer_write_enable, 1);
    chk("wrap_pos", position, 239);
    chk("wrap_code", char_code, 7'h5A);
    step();
    chk("wrap_cx", cursor_x, 0);
    chk("wrap_cy", cursor_y, 3);

    for (int i = 0; i < 26; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h2E);
    step();
    wait_ready();
    chk("pre_lf_cx", cursor_x, 5);
    chk("pre_lf_cy", cursor_y, 29);
    send(8'h0A);
    chk("lf_wrap_no_we", buffer_write_enable, 0);
    step();
    chk("lf_wrap_cx", cursor_x, 0);
    chk("lf_wrap_cy", cursor_y, 0);

    send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h61);
    step();
    wait_ready();
    chk("pre_bs_cx", cursor_x, 3);
    chk("pre_bs_cy", cursor_y, 1);
    send(8'h08);
    chk("bs_we", buffer_write_enable, 1);
    chk("bs_pos", position, 82);
    chk("bs_code", char_code, 7'h20);
    step();
    chk("bs_cx", cursor_x, 2);
    chk("bs_cy", cursor_y, 1);

    send(8'h0D);
    step();
    chk("cr_cx", cursor_x, 0);
    chk("cr_cy", cursor_y, 1);
    for (int i = 0; i < 3; i++) send(8'h0A);
    send(8'h08);
    chk("bs0_no_we", buffer_write_enable, 0);
    step();
    chk("bs0_cx", cursor_x, 0);
    chk("bs0_cy", cursor_y, 4);

    send(8'h7F);
    chk("del_no_we", buffer_write_enable, 0);
    chk("del_pos_hold", position, 82);
    chk("del_code_hold", char_code, 7'h20);
    step();
    chk("del_cx", cursor_x, 0);
    chk("del_cy", cursor_y, 4);

    wait_ready();
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_in    = 8'h41;
    #1;
    chk("creq_ready_low", char_ready, 0);
    step();
    clear_req  = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;
    chk("creq_no_we", buffer_write_enable, 0);
    chk("creq_busy", busy, 1);
    chk("creq_not_consumed", cursor_x, 0);
    errs = 0;
    for (int i = 0; i <= 1000; i++) begin
      step();
      if (buffer_write_enable !== 1'b1 || position !== 12'(i) || char_code !== 7'h20) errs++;
    end
    chk("creq_partial_clear", errs, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", buffer_write_enable, 0);
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_code", char_code, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", char_ready, 0);
    chk("mid_rst_cy", cursor_y, 0);
    step();
    reset = 1'b1;
    run_clear("restart_clear");

    send(8'h51);
    step();
    send(8'h0C);
    chk("ff_no_we", buffer_write_enable, 0);
    chk("ff_busy", busy, 1);
    chk("ff_ready_low", char_ready, 0);
    run_clear("ff_clear");

`ifdef TEXT_CONSOLE_LINE_CLEAR_EN
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h62);
    step();
    wait_ready();
    chk("lc_pre_cx", cursor_x, 7);
    chk("lc_pre_cy", cursor_y, 2);
    send(8'h0A);
    chk("lc_write_no_we", buffer_write_enable, 0);
    step();
    chk("lc_busy", busy, 1);
    chk("lc_ready_low", char_ready, 0);
    errs = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (buffer_write_enable !== 1'b1 || position !== 12'(240 + i) || char_code !== 7'h20) errs++;
    end
    chk("lc_row_clear", errs, 0);
    step();
    chk("lc_busy_done", busy, 0);
    chk("lc_cx", cursor_x, 0);
    chk("lc_cy", cursor_y, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
